bist_response_analyzer: RTL and testbench
=========================================

BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

Interface
REQ-001 Parameter CHAIN_LEN, default 8: scan-chain length in flops; the shift and unload phases each last CHAIN_LEN cycles.
REQ-002 Parameter NUM_PATTERNS, default 8: number of shift+capture iterations per test run; legal range 1..255.
REQ-003 Parameter SEED, default 8'h00: MISR value loaded at reset and at every run start.
REQ-004 Parameter GOLDEN, default 8'h00: expected final signature.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  run request pulse; sampled only in IDLE or DONE.
REQ-008 scan_out  input  1  serial response from the scan-chain tail; valid in every cycle in which scan_en=1.
REQ-009 scan_en  output  1  scan-chain mode select: 1 = shift, 0 = capture or hold.
REQ-010 busy  output  1  high in SHIFT, CAPTURE and UNLOAD.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  equals done AND (signature == GOLDEN).
REQ-013 signature  output  8  current MISR contents.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, CAPTURE, UNLOAD and DONE, held in a registered state variable; scan_en, busy and done SHALL be decoded from the state only.
REQ-015 IDLE/DONE with start=1: next state SHIFT, bit_cnt=0, pat_cnt=0, signature=SEED; with start=0 the state SHALL be held.
REQ-016 SHIFT: scan_en=1; bit_cnt increments each cycle; when bit_cnt==CHAIN_LEN-1 the next state SHALL be CAPTURE and bit_cnt SHALL clear.
REQ-017 CAPTURE: scan_en=0 for exactly 1 cycle; if pat_cnt==NUM_PATTERNS-1 the next state SHALL be UNLOAD, otherwise pat_cnt increments and the next state SHALL be SHIFT.
REQ-018 UNLOAD: scan_en=1 for CHAIN_LEN cycles, counted by bit_cnt; it then goes to DONE.
REQ-019 A run SHALL therefore be busy for NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN cycles; with the defaults this is 80.
REQ-020 MISR update SHALL happen only on edges where scan_en=1: fb = signature[7] XOR scan_out; next[0]=fb; next[1]=sig[0]; next[2]=sig[1]^fb; next[3]=sig[2]^fb; next[4]=sig[3]^fb; next[7:5]=sig[6:4] (polynomial x^8+x^4+x^3+x^2+1).
REQ-021 The MISR SHALL hold its value in IDLE, CAPTURE and DONE.
REQ-022 start while busy=1 SHALL be ignored and SHALL have no effect on counters, state or MISR.
REQ-023 start in DONE SHALL clear done and pass on the next edge and restart the run with the MISR reloaded to SEED.
REQ-024 pass SHALL be 0 whenever done=0; signature SHALL stay stable and readable throughout DONE.
REQ-025 Counters SHALL be wide enough for CHAIN_LEN-1 and NUM_PATTERNS-1 with no wrap inside a run.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force: state=IDLE, bit_cnt=0, pat_cnt=0, signature=SEED, and scan_en=busy=done=pass=0.
REQ-027 Reset asserted mid-run, in any state, SHALL abort the run with no partial-result retention; a new start is required.
REQ-028 start sampled together with rst_n=0 SHALL be ignored.

Verification
REQ-029 Defaults, scan_out tied 0, one start pulse -> scan_en pattern is (8x1, 1x0) repeated 8 times, then 8x1; busy is high for exactly 80 cycles; done rises; signature=8'h00; pass=1.
REQ-030 SEED=0, scan_out=1 on the first SHIFT cycle only, then 0 -> signature=8'h1D after the first shift edge and 8'h3A after the second.
REQ-031 start pulses on cycles 5, 20 and 79 of a run -> run length and final signature are identical to REQ-029.
REQ-032 rst_n=0 for 1 cycle during the 3rd CAPTURE -> the next cycle shows IDLE, signature=SEED and all outputs 0; a following start gives a full 80-cycle run.
REQ-033 Closed loop with the LFSR-driven 8-flop multiplier scan chain, GOLDEN set to the result from the model's golden run -> pass=1; a stuck-at-0 injected on one multiplier product bit -> pass=0 and done=1.
REQ-034 start in DONE -> on the next edge done=0 and pass=0, and the MISR is reloaded to SEED; NUM_PATTERNS=1 gives a 17-cycle busy window.

Source files
------------

// File: rtl/bist_response_analyzer.sv
// Sequences scan shift/capture/unload for a BIST run and compacts the serial
// scan response into an 8-bit MISR; pass flags a match against GOLDEN once the run completes.
module bist_response_analyzer #(
   parameter int          CHAIN_LEN    = 8,
   parameter int          NUM_PATTERNS = 8,
   parameter logic [7:0]  SEED         = 8'h00,
   parameter logic [7:0]  GOLDEN       = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       scan_out,
   output logic       scan_en,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] signature
);

   localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam int PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
   localparam logic [PW-1:0] PAT_LAST = PW'(NUM_PATTERNS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CAPTURE,
      UNLOAD,
      DONE
   } state_t;

   state_t          state;
   logic [BW-1:0]   bit_cnt;
   logic [PW-1:0]   pat_cnt;
   logic            fb;
   logic [7:0]      misr_next;

   // x^8+x^4+x^3+x^2+1, response bit folded in at the feedback tap
   assign fb        = signature[7] ^ scan_out;
   assign misr_next = {signature[6:4], signature[3] ^ fb, signature[2] ^ fb,
                       signature[1] ^ fb, signature[0], fb};

   assign pass = done && (signature == GOLDEN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         pat_cnt   <= '0;
         signature <= SEED;
         scan_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         // scan_en is registered with the state, so it is high exactly in SHIFT/UNLOAD
         if (scan_en) begin
            signature <= misr_next;
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= SHIFT;
                  bit_cnt   <= '0;
                  pat_cnt   <= '0;
                  signature <= SEED;
                  scan_en   <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_cnt == BIT_LAST) begin
                  state   <= CAPTURE;
                  bit_cnt <= '0;
                  scan_en <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            CAPTURE: begin
               scan_en <= 1'b1;
               if (pat_cnt == PAT_LAST) begin
                  state <= UNLOAD;
               end else begin
                  pat_cnt <= pat_cnt + 1'b1;
                  state   <= SHIFT;
               end
            end
            UNLOAD: begin
               if (bit_cnt == BIT_LAST) begin
                  state   <= DONE;
                  bit_cnt <= '0;
                  scan_en <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               bit_cnt <= '0;
               pat_cnt <= '0;
               scan_en <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: default instance, single-pattern instance
// and a closed-loop instance driven by an LFSR-fed multiplier scan chain.
module tb_bist_response_analyzer;

   localparam int CL = 8;
   localparam int NP = 8;
   localparam int RUN_LEN = NP * (CL + 1) + CL;

   typedef struct {
      logic [7:0] sig;
      int         len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n, start, scan_out;
   logic       scan_en, busy, done, pass;
   logic [7:0] signature;
   logic       start1, scan_out1;
   logic       scan_en1, busy1, done1, pass1;
   logic [7:0] signature1;
   logic       start_cl, inject;
   logic       cl_scan_en, cl_busy, cl_done, cl_pass;
   logic [7:0] cl_sig;
   logic [7:0] chain, lfsr;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [7:0] misr_step(input logic [7:0] s, input logic b);
      logic f;
      f = s[7] ^ b;
      return {s[6:4], s[3] ^ f, s[2] ^ f, s[1] ^ f, s[0], f};
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [7:0] mult(input logic [7:0] c, input logic fault);
      logic [7:0] p;
      p = c[7:4] * c[3:0];
      if (fault) p[3] = 1'b0;
      return p;
   endfunction

   // Reference run of the whole closed loop: chain, pattern LFSR and MISR
   function automatic logic [7:0] cl_model(input logic fault);
      logic [7:0] s, c, l;
      s = 8'h00;
      c = 8'h00;
      l = 8'hA5;
      for (int p = 0; p < NP; p++) begin
         for (int b = 0; b < CL; b++) begin
            s = misr_step(s, c[7]);
            c = {c[6:0], l[0]};
            l = lfsr_step(l);
         end
         c = mult(c, fault);
      end
      for (int b = 0; b < CL; b++) begin
         s = misr_step(s, c[7]);
         c = {c[6:0], l[0]};
         l = lfsr_step(l);
      end
      return s;
   endfunction

   bist_response_analyzer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .scan_out(scan_out),
      .scan_en(scan_en), .busy(busy), .done(done), .pass(pass), .signature(signature)
   );

   bist_response_analyzer #(.NUM_PATTERNS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .scan_out(scan_out1),
      .scan_en(scan_en1), .busy(busy1), .done(done1), .pass(pass1), .signature(signature1)
   );

   bist_response_analyzer #(.GOLDEN(cl_model(1'b0))) dut_cl (
      .clk(clk), .rst_n(rst_n), .start(start_cl), .scan_out(chain[7]),
      .scan_en(cl_scan_en), .busy(cl_busy), .done(cl_done), .pass(cl_pass), .signature(cl_sig)
   );

   always @(posedge clk) begin
      if (!rst_n || (start_cl && !cl_busy)) begin
         chain <= 8'h00;
         lfsr  <= 8'hA5;
      end else if (cl_scan_en) begin
         chain <= {chain[6:0], lfsr[0]};
         lfsr  <= lfsr_step(lfsr);
      end else if (cl_busy) begin
         chain <= mult(chain, inject);
      end
   end

   // mode 0: scan_out=0, 1: single 1 on first shift, 2: random, 3: zeros plus starts while busy
   task automatic drive_run(input int mode, output int len, output int se_err,
                            output logic [7:0] s1, output logic [7:0] s2,
                            output logic f_done, output logic f_pass,
                            output logic f_busy, output logic [7:0] f_sig);
      exp_t       e;
      logic [7:0] m;
      logic       exp_se;
      int         k;
      m = 8'h00;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      f_done = done; f_pass = pass; f_busy = busy; f_sig = signature;
      k = 0; se_err = 0; s1 = 8'h00; s2 = 8'h00;
      while (busy && k < 300) begin
         exp_se = (k < NP * (CL + 1)) ? ((k % (CL + 1)) != CL) : 1'b1;
         if (scan_en !== exp_se) se_err++;
         if (k == 1) s1 = signature;
         if (k == 2) s2 = signature;
         case (mode)
            1:       scan_out = (k == 0);
            2:       scan_out = 1'($urandom_range(0, 1));
            default: scan_out = 1'b0;
         endcase
         start = (mode == 3) && (k == 5 || k == 20 || k == 79);
         if (exp_se) m = misr_step(m, scan_out);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      scan_out = 1'b0;
      len = k;
      e.sig = m;
      e.len = RUN_LEN;
      sb.push_back(e);
   endtask

   task automatic check_run(input string name, input int len, input int se_err);
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (len !== e.len) begin
         miscompares++;
         $display("FAIL %s busy_len: got %0d want %0d", name, len, e.len);
      end
      vectors++;
      if (se_err !== 0) begin
         miscompares++;
         $display("FAIL %s scan_en_pattern: got %0d bad cycles want 0", name, se_err);
      end
      vectors++;
      if (signature !== e.sig) begin
         miscompares++;
         $display("FAIL %s signature: got %h want %h", name, signature, e.sig);
      end
      vectors++;
      if (done !== 1'b1 || pass !== (e.sig == 8'h00)) begin
         miscompares++;
         $display("FAIL %s done_pass: got %b%b want 1%b", name, done, pass, (e.sig == 8'h00));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; start1 = 1'b1; start_cl = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({scan_en, busy, done, pass} !== 4'b0000 || signature !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b sig %h want 0000 sig 00",
                  {scan_en, busy, done, pass}, signature);
      end
      rst_n = 1'b1; start = 1'b0; start1 = 1'b0; start_cl = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, busy1, cl_busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_start_ignored: got busy %b want 000", {busy, busy1, cl_busy});
      end
   endtask

   task automatic test_zero_run();
      int len, se; logic [7:0] s1, s2, fs; logic fd, fp, fb;
      drive_run(0, len, se, s1, s2, fd, fp, fb, fs);
      check_run("zero_run", len, se);
   endtask

   task automatic test_first_shift();
      int len, se; logic [7:0] s1, s2, fs; logic fd, fp, fb;
      drive_run(1, len, se, s1, s2, fd, fp, fb, fs);
      vectors++;
      if (s1 !== 8'h1D) begin
         miscompares++;
         $display("FAIL first_shift_sig1: got %h want 1d", s1);
      end
      vectors++;
      if (s2 !== 8'h3A) begin
         miscompares++;
         $display("FAIL first_shift_sig2: got %h want 3a", s2);
      end
      check_run("first_shift", len, se);
   endtask

   task automatic test_start_while_busy();
      int len, se; logic [7:0] s1, s2, fs; logic fd, fp, fb;
      drive_run(3, len, se, s1, s2, fd, fp, fb, fs);
      check_run("start_busy", len, se);
   endtask

   task automatic test_done_hold_restart();
      int len, se; logic [7:0] s1, s2, fs, held; logic fd, fp, fb;
      drive_run(2, len, se, s1, s2, fd, fp, fb, fs);
      check_run("random_run", len, se);
      held = signature;
      repeat (3) @(negedge clk);
      vectors++;
      if (done !== 1'b1 || signature !== held) begin
         miscompares++;
         $display("FAIL done_hold: got done %b sig %h want 1 sig %h", done, signature, held);
      end
      drive_run(0, len, se, s1, s2, fd, fp, fb, fs);
      vectors++;
      if ({fd, fp, fb} !== 3'b001 || fs !== 8'h00) begin
         miscompares++;
         $display("FAIL restart_reload: got dpb %b sig %h want 001 sig 00", {fd, fp, fb}, fs);
      end
      check_run("restart_zero", len, se);
      drive_run(2, len, se, s1, s2, fd, fp, fb, fs);
      vectors++;
      if ({fd, fp, fb} !== 3'b001) begin
         miscompares++;
         $display("FAIL restart_clear_pass: got dpb %b want 001", {fd, fp, fb});
      end
      check_run("restart_random", len, se);
   endtask

   task automatic test_mid_reset();
      int len, se; logic [7:0] s1, s2, fs; logic fd, fp, fb;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 2 * (CL + 1) + CL; k++) begin
         scan_out = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      scan_out = 1'b0;
      vectors++;
      if (busy !== 1'b1 || scan_en !== 1'b0) begin
         miscompares++;
         $display("FAIL third_capture: got busy %b scan_en %b want 1 0", busy, scan_en);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if ({scan_en, busy, done, pass} !== 4'b0000 || signature !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_reset: got %b sig %h want 0000 sig 00",
                  {scan_en, busy, done, pass}, signature);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_idle: got busy %b want 0", busy);
      end
      drive_run(0, len, se, s1, s2, fd, fp, fb, fs);
      check_run("after_reset", len, se);
   endtask

   task automatic test_short_run();
      int k;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      k = 0;
      while (busy1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (k !== CL + 1 + CL || done1 !== 1'b1 || pass1 !== 1'b1) begin
         miscompares++;
         $display("FAIL short_run: got len %0d done %b pass %b want 17 1 1", k, done1, pass1);
      end
   endtask

   task automatic test_closed_loop(input logic fault);
      exp_t e;
      int   k;
      inject = fault;
      e.sig = cl_model(fault);
      e.len = RUN_LEN;
      sb.push_back(e);
      @(negedge clk); start_cl = 1'b1;
      @(negedge clk); start_cl = 1'b0;
      k = 0;
      while (!cl_done && k < 300) begin
         @(negedge clk);
         k++;
      end
      e = sb.pop_front();
      vectors++;
      if (k !== e.len) begin
         miscompares++;
         $display("FAIL closed_loop_len f=%b: got %0d want %0d", fault, k, e.len);
      end
      vectors++;
      if (cl_sig !== e.sig) begin
         miscompares++;
         $display("FAIL closed_loop_sig f=%b: got %h want %h", fault, cl_sig, e.sig);
      end
      vectors++;
      if (cl_done !== 1'b1 || cl_pass !== !fault) begin
         miscompares++;
         $display("FAIL closed_loop_pass f=%b: got done %b pass %b want 1 %b",
                  fault, cl_done, cl_pass, !fault);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; scan_out = 1'b0;
      start1 = 1'b0; scan_out1 = 1'b0; start_cl = 1'b0; inject = 1'b0;
      test_reset();
      test_zero_run();
      test_first_shift();
      test_start_while_busy();
      test_done_hold_restart();
      test_mid_reset();
      test_short_run();
      test_closed_loop(1'b0);
      test_closed_loop(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
